// File: rtl/demux_4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_4_stream
// Description : 1-to-4 registered valid/ready stream demultiplexer with a
//               per-packet destination lock and one buffer stage per channel.
//               Optional per-channel beat counters: define DEMUX_BEAT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_4_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       sel,
    output logic             out_a_valid,
    output logic             out_b_valid,
    output logic             out_c_valid,
    output logic             out_d_valid,
    input  logic             out_a_ready,
    input  logic             out_b_ready,
    input  logic             out_c_ready,
    input  logic             out_d_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic [WIDTH-1:0] out_b_data,
    output logic [WIDTH-1:0] out_c_data,
    output logic [WIDTH-1:0] out_d_data,
    output logic             out_a_last,
    output logic             out_b_last,
    output logic             out_c_last,
    output logic             out_d_last,
`ifdef DEMUX_BEAT_CNT_EN
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b,
    output logic [7:0]       cnt_c,
    output logic [7:0]       cnt_d,
`endif
    output logic             busy
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_sel;
    logic             r_busy;

    logic [3:0]       r_valid;
    logic [3:0]       r_last;
    logic [WIDTH-1:0] r_data [4];

    logic [3:0]       w_oready;
    logic [3:0]       w_free;
    logic [1:0]       w_dest;
    logic             w_accept;

    assign w_oready = {out_d_ready, out_c_ready, out_b_ready, out_a_ready};
    assign w_dest   = (r_state == S_LOCKED) ? r_sel : sel;
    // A channel can take a new beat if empty or draining this same cycle.
    assign w_free   = ~r_valid | w_oready;
    assign in_ready = w_free[w_dest];
    assign w_accept = in_valid & in_ready;
    assign busy     = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 2'b00;
            r_busy  <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (!in_last) begin
                        r_state <= S_LOCKED;
                        r_sel   <= sel;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (in_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_ch
            localparam logic [1:0] c_idx = 2'(k);
            logic w_load;
            assign w_load = w_accept && (w_dest == c_idx);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_last[k]  <= 1'b0;
                    r_data[k]  <= '0;
                end else if (w_load) begin
                    r_valid[k] <= 1'b1;
                    r_last[k]  <= in_last;
                    r_data[k]  <= in_data;
                end else if (w_oready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end

`ifdef DEMUX_BEAT_CNT_EN
            logic [7:0] r_cnt;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= 8'd0;
                end else if (w_load) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
`endif
        end
    endgenerate

`ifdef DEMUX_BEAT_CNT_EN
    assign cnt_a = g_ch[0].r_cnt;
    assign cnt_b = g_ch[1].r_cnt;
    assign cnt_c = g_ch[2].r_cnt;
    assign cnt_d = g_ch[3].r_cnt;
`endif

    assign out_a_valid = r_valid[0];
    assign out_b_valid = r_valid[1];
    assign out_c_valid = r_valid[2];
    assign out_d_valid = r_valid[3];
    assign out_a_last  = r_last[0];
    assign out_b_last  = r_last[1];
    assign out_c_last  = r_last[2];
    assign out_d_last  = r_last[3];
    assign out_a_data  = r_data[0];
    assign out_b_data  = r_data[1];
    assign out_c_data  = r_data[2];
    assign out_d_data  = r_data[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_4_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_4_stream
// Description : Bench for demux_4_stream: directed scenarios plus random
//               traffic against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_4_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic [1:0]   sel;
    logic         out_a_valid, out_b_valid, out_c_valid, out_d_valid;
    logic         out_a_ready, out_b_ready, out_c_ready, out_d_ready;
    logic [W-1:0] out_a_data, out_b_data, out_c_data, out_d_data;
    logic         out_a_last, out_b_last, out_c_last, out_d_last;
    logic         busy;
`ifdef DEMUX_BEAT_CNT_EN
    logic [7:0]   cnt_a, cnt_b, cnt_c, cnt_d;
`endif

    demux_4_stream #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .sel(sel),
        .out_a_valid(out_a_valid), .out_b_valid(out_b_valid),
        .out_c_valid(out_c_valid), .out_d_valid(out_d_valid),
        .out_a_ready(out_a_ready), .out_b_ready(out_b_ready),
        .out_c_ready(out_c_ready), .out_d_ready(out_d_ready),
        .out_a_data(out_a_data), .out_b_data(out_b_data),
        .out_c_data(out_c_data), .out_d_data(out_d_data),
        .out_a_last(out_a_last), .out_b_last(out_b_last),
        .out_c_last(out_c_last), .out_d_last(out_d_last),
`ifdef DEMUX_BEAT_CNT_EN
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // DUT outputs gathered per channel index
    logic [3:0]   rdy, dv, dl;
    logic [W-1:0] dd [4];
    always_comb begin
        rdy   = {out_d_ready, out_c_ready, out_b_ready, out_a_ready};
        dv    = {out_d_valid, out_c_valid, out_b_valid, out_a_valid};
        dl    = {out_d_last, out_c_last, out_b_last, out_a_last};
        dd[0] = out_a_data;
        dd[1] = out_b_data;
        dd[2] = out_c_data;
        dd[3] = out_d_data;
    end

    // Reference model: packet lock plus "each channel holds at most one beat".
    bit           started = 0;
    bit           m_in_pkt;
    int           m_pkt_ch;
    bit           m_occ  [4];
    logic [W-1:0] m_data [4];
    bit           m_last [4];
    int           m_cnt  [4];

    function automatic int m_dest();
        return m_in_pkt ? m_pkt_ch : int'(sel);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_in_pkt = 0;
            m_pkt_ch = 0;
            for (int k = 0; k < 4; k++) begin
                m_occ[k] = 0; m_data[k] = '0; m_last[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            int  d;
            bit  acc;
            d   = m_dest();
            acc = in_valid && (!m_occ[d] || rdy[d]);
            for (int k = 0; k < 4; k++)
                if (m_occ[k] && rdy[k]) m_occ[k] = 0;
            if (acc) begin
                m_occ[d]  = 1;
                m_data[d] = in_data;
                m_last[d] = in_last;
                m_cnt[d]  = (m_cnt[d] + 1) % 256;
                if (!m_in_pkt && !in_last) begin
                    m_in_pkt = 1;
                    m_pkt_ch = int'(sel);
                end else if (m_in_pkt && in_last) begin
                    m_in_pkt = 0;
                end
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            int d;
            d = m_dest();
            chk("in_ready", 32'(in_ready), 32'(!m_occ[d] || rdy[d]));
            chk("busy", 32'(busy), 32'(m_in_pkt));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("valid[%0d]", k), 32'(dv[k]), 32'(m_occ[k]));
                if (m_occ[k]) begin
                    chk($sformatf("data[%0d]", k), 32'(dd[k]), 32'(m_data[k]));
                    chk($sformatf("last[%0d]", k), 32'(dl[k]), 32'(m_last[k]));
                end
            end
`ifdef DEMUX_BEAT_CNT_EN
            chk("cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
            chk("cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
            chk("cnt_c", 32'(cnt_c), 32'(m_cnt[2]));
            chk("cnt_d", 32'(cnt_d), 32'(m_cnt[3]));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_ready(input logic v);
        out_a_ready = v; out_b_ready = v; out_c_ready = v; out_d_ready = v;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0; sel = 2'd0;
        all_ready(1'b1);

        // Reset held two cycles with in_valid asserted
        step(); step();
        chk("rst valids", 32'(dv), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst a_data", 32'(out_a_data), 32'h0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'h1);
        step();

        // Single-beat packets to every channel
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; sel = 2'(k); in_data = 8'(8'h11 * (k + 1)); in_last = 1'b1;
            step();
            chk("single valid", 32'(dv), 32'(1 << k));
            chk("single data", 32'(dd[k]), 32'(8'h11 * (k + 1)));
            chk("single busy", 32'(busy), 32'h0);
        end
        in_valid = 1'b0;
        step();

        // Sel lock over a 3-beat packet
        in_valid = 1'b1; sel = 2'd2; in_data = 8'hA0; in_last = 1'b0;
        step();
        chk("lock busy0", 32'(busy), 32'h1);
        chk("lock c0", 32'(out_c_data), 32'hA0);
        sel = 2'd1; in_data = 8'hA1;
        step();
        chk("lock c1", 32'(out_c_data), 32'hA1);
        in_data = 8'hA2; in_last = 1'b1;
        step();
        chk("lock c2", 32'(out_c_data), 32'hA2);
        chk("lock b idle", 32'(out_b_valid), 32'h0);
        chk("lock busy2", 32'(busy), 32'h0);
        in_valid = 1'b0;
        step();

        // Backpressure on b
        out_b_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd1; in_data = 8'hB0; in_last = 1'b1;
        step();
        in_data = 8'hB1;
        #1;
        chk("bp stall ready", 32'(in_ready), 32'h0);
        step();
        chk("bp hold", 32'(out_b_data), 32'hB0);
        out_b_ready = 1'b1;
        #1;
        chk("bp release ready", 32'(in_ready), 32'h1);
        step();
        chk("bp second", 32'(out_b_data), 32'hB1);
        in_valid = 1'b0;
        step();
        chk("bp drained", 32'(out_b_valid), 32'h0);

        // Channel a stalled while d streams back-to-back
        out_a_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd0; in_data = 8'h55; in_last = 1'b1;
        step();
        sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'hD0 + i); in_last = (i == 3);
            step();
            chk("indep d", 32'(out_d_data), 32'(8'hD0 + i));
            chk("indep a", 32'(out_a_data), 32'h55);
        end
        in_valid = 1'b0; out_a_ready = 1'b1;
        step();

`ifdef DEMUX_BEAT_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b1; sel = 2'd0; in_last = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("cnt wrap a", 32'(cnt_a), 32'h1);
        chk("cnt others", 32'({cnt_b, cnt_c, cnt_d}), 32'h0);
        in_valid = 1'b1; sel = 2'd2; in_last = 1'b0;
        step();
        chk("cnt pkt busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        step();
        chk("cnt rst", 32'({cnt_a, cnt_b, cnt_c, cnt_d}), 32'h0);
        chk("cnt rst busy", 32'(busy), 32'h0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            sel         = 2'($urandom_range(0, 3));
            in_data     = 8'($urandom);
            in_last     = ($urandom_range(0, 3) == 0);
            out_a_ready = ($urandom_range(0, 3) != 0);
            out_b_ready = ($urandom_range(0, 3) != 0);
            out_c_ready = ($urandom_range(0, 1) != 0);
            out_d_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; rst_n = 1'b1;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
